// File: rtl/spi_master_cfg_if.sv
// Control/status and SPI pin bundle for spi_master_cfg.
// The master modport is the SPI master's view; slave is the controlling side.
interface spi_master_cfg_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [WIDTH-1:0]  tx_data;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  clk_div;
  logic [CS_W-1:0]   cs_sel;
  logic [WIDTH-1:0]  rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic [NUM_CS-1:0] cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
    output rx_data, rx_valid, busy, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
    input  rx_data, rx_valid, busy, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Configurable full-duplex SPI master: run-time CPOL/CPHA, SCLK divider,
// bit order and one-hot chip select; one WIDTH-bit word per accepted start.
module spi_master_cfg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_cfg_if.master  bus
);
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edges;
  logic [WIDTH-1:0]  tx_sh;
  logic [WIDTH-1:0]  rx_sh;
  logic              cpha_q;
  logic              lsb_q;
  logic              leading;

  // edges counts toggles already made, so an even count means the next toggle is a leading edge
  assign leading = ~edges[0];

  function automatic logic first_bit(input logic [WIDTH-1:0] word, input logic lsb);
    return lsb ? word[0] : word[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word, input logic lsb);
    return lsb ? (word >> 1) : (word << 1);
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b,
                                                input logic lsb);
    return lsb ? {b, word[WIDTH-1:1]} : {word[WIDTH-2:0], b};
  endfunction

  // An out-of-range index leaves every select deasserted
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] lines;
    lines = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) lines[i] = 1'b0;
    end
    return lines;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      div_q        <= '0;
      edges        <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      bus.sclk     <= 1'b0;
      bus.cs_n     <= '1;
      bus.mosi     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.sclk <= bus.cpol;
          if (bus.start) begin
            cpha_q   <= bus.cpha;
            lsb_q    <= bus.lsb_first;
            div_q    <= bus.clk_div;
            cnt      <= '0;
            edges    <= '0;
            bus.cs_n <= cs_decode(bus.cs_sel);
            bus.busy <= 1'b1;
            state    <= LEAD;
            // CPHA=0 presents the first bit before any clock edge
            if (!bus.cpha) begin
              bus.mosi <= first_bit(bus.tx_data, bus.lsb_first);
              tx_sh    <= shift_out(bus.tx_data, bus.lsb_first);
            end else begin
              bus.mosi <= 1'b0;
              tx_sh    <= bus.tx_data;
            end
          end
        end

        LEAD: begin
          if (cnt == div_q) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          if (cnt == div_q) begin
            cnt      <= '0;
            bus.sclk <= ~bus.sclk;
            edges    <= edges + 1'b1;
            if (leading ^ cpha_q) begin
              rx_sh <= shift_in(rx_sh, bus.miso, lsb_q);
            end
            // The final trailing edge in CPHA=0 has no further bit to present
            if ((cpha_q && leading) || (!cpha_q && !leading && edges != LAST_EDGE)) begin
              bus.mosi <= first_bit(tx_sh, lsb_q);
              tx_sh    <= shift_out(tx_sh, lsb_q);
            end
            if (edges == LAST_EDGE) begin
              state <= TRAIL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        TRAIL: begin
          if (cnt == div_q) begin
            cnt          <= '0;
            state        <= IDLE;
            bus.cs_n     <= '1;
            bus.rx_data  <= rx_sh;
            bus.rx_valid <= 1'b1;
            bus.busy     <= 1'b0;
            bus.mosi     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Randomised bench for spi_master_cfg against a cycle-offset reference model,
// with a second 3-select instance that always receives an out-of-range select.
module tb_spi_master_cfg;
  localparam int W   = 8;
  localparam int NCS = 4;
  localparam int DW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_master_cfg_if #(.WIDTH(W), .NUM_CS(NCS), .DIV_W(DW)) bus ();
  spi_master_cfg_if #(.WIDTH(W), .NUM_CS(3),   .DIV_W(DW)) bus3 ();

  spi_master_cfg #(.WIDTH(W), .NUM_CS(NCS), .DIV_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  spi_master_cfg #(.WIDTH(W), .NUM_CS(3), .DIV_W(DW)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  assign bus3.start     = bus.start;
  assign bus3.tx_data   = bus.tx_data;
  assign bus3.cpol      = bus.cpol;
  assign bus3.cpha      = bus.cpha;
  assign bus3.lsb_first = bus.lsb_first;
  assign bus3.clk_div   = bus.clk_div;
  assign bus3.cs_sel    = 2'd3;
  assign bus3.miso      = bus.miso;

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state: a transfer is described only by its offset from acceptance
  bit          m_active = 1'b0;
  int          m_t, m_h, pc, cyc, accept_cyc, pulses, last_pulses;
  bit          m_cpol, m_cpha, m_lsb, m_loop, done_now;
  logic [1:0]  m_sel;
  logic [W-1:0] m_tx, m_resp, rx_hold, mosi_word, last_mosi_word;
  logic [W-1:0] resp_word;
  bit          loop_mode;
  logic        prev_mosi, prev_sclk, cpol_in;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic int toggles(input int t, input int h);
    int c;
    c = t / h - 1;
    if (c < 0) c = 0;
    if (c > 2 * W) c = 2 * W;
    return c;
  endfunction

  function automatic logic bitseq(input logic [W-1:0] word, input int j, input bit lsb);
    return lsb ? word[j] : word[W-1-j];
  endfunction

  function automatic logic [NCS-1:0] decode(input logic [1:0] sel);
    logic [NCS-1:0] oh;
    oh = '0;
    if (int'(sel) < NCS) oh[sel] = 1'b1;
    return ~oh;
  endfunction

  initial begin : monitor
    int c, s, idx;
    logic       exp_sclk, exp_busy;
    logic [NCS-1:0] exp_cs;
    bus.miso  = 1'b0;
    prev_mosi = 1'b0;
    prev_sclk = 1'b0;
    rx_hold   = '0;
    cyc       = 0;
    forever begin
      @(posedge clk);
      cyc++;
      done_now = 1'b0;
      cpol_in  = bus.cpol;
      if (!rst_n) begin
        m_active = 1'b0;
        rx_hold  = '0;
      end else if (m_active) begin
        m_t++;
        if (m_t == (2 * W + 2) * m_h) begin
          m_active       = 1'b0;
          done_now       = 1'b1;
          rx_hold        = m_loop ? m_tx : m_resp;
          last_mosi_word = mosi_word;
          last_pulses    = pulses;
        end
      end else if (bus.start) begin
        m_active   = 1'b1;
        m_t        = 0;
        m_h        = int'(bus.clk_div) + 1;
        m_cpol     = bus.cpol;
        m_cpha     = bus.cpha;
        m_lsb      = bus.lsb_first;
        m_sel      = bus.cs_sel;
        m_tx       = bus.tx_data;
        m_resp     = resp_word;
        m_loop     = loop_mode;
        mosi_word  = '0;
        pulses     = 0;
        pc         = 0;
        accept_cyc = cyc;
      end
      #1;
      if (!rst_n) begin
        exp_sclk = 1'b0;
        exp_cs   = '1;
        exp_busy = 1'b0;
        check_output("mosi_reset", bus.mosi, 1'b0);
      end else if (m_active) begin
        c        = toggles(m_t, m_h);
        exp_sclk = m_cpol ^ (c % 2 == 1);
        exp_cs   = decode(m_sel);
        exp_busy = 1'b1;
        // The slave sees the mosi level that was present just before a sampling edge
        if (c != pc && (m_cpha ? (c % 2 == 0) : (c % 2 == 1))) begin
          idx = m_cpha ? c / 2 - 1 : (c - 1) / 2;
          check_output("mosi_bit", prev_mosi, bitseq(m_tx, idx, m_lsb));
          if (m_lsb) mosi_word[idx] = prev_mosi;
          else       mosi_word[W-1-idx] = prev_mosi;
        end
        if (bus.sclk != prev_sclk && bus.sclk != m_cpol) pulses++;
        pc = c;
      end else begin
        exp_sclk = done_now ? m_cpol : cpol_in;
        exp_cs   = '1;
        exp_busy = 1'b0;
        check_output("mosi_idle", bus.mosi, 1'b0);
      end
      check_output("sclk", bus.sclk, exp_sclk);
      check_output("cs_n", bus.cs_n, exp_cs);
      check_output("busy", bus.busy, exp_busy);
      check_output("rx_valid", bus.rx_valid, done_now);
      check_output("rx_data", bus.rx_data, rx_hold);
      check_output("cs3_n", bus3.cs_n, 3'b111);
      check_output("rx3_valid", bus3.rx_valid, done_now);
      check_output("rx3_data", bus3.rx_data, rx_hold);
      prev_mosi = bus.mosi;
      prev_sclk = bus.sclk;
      if (rst_n && m_active) begin
        s = m_cpha ? c / 2 : (c + 1) / 2;
        if (m_loop)     bus.miso = bus.mosi;
        else if (s < W) bus.miso = bitseq(m_resp, s, m_lsb);
        else            bus.miso = 1'b0;
      end else begin
        bus.miso = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] tx, input logic [W-1:0] resp, input bit loop,
                                input bit cpol, input bit cpha, input bit lsb,
                                input logic [DW-1:0] div, input logic [1:0] sel);
    @(negedge clk);
    resp_word     = resp;
    loop_mode     = loop;
    bus.tx_data   = tx;
    bus.cpol      = cpol;
    bus.cpha      = cpha;
    bus.lsb_first = lsb;
    bus.clk_div   = div;
    bus.cs_sel    = sel;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      @(posedge clk);
      #2;
      if (bus.rx_valid) seen = 1'b1;
    end
    lat = cyc - accept_cyc;
    if (!seen) check_output("rx_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stimulus
    int lat;
    logic [W-1:0] tx, rp;
    logic [DW-1:0] dv;
    bit lp;
    bus.start     = 1'b0;
    bus.tx_data   = '0;
    bus.cpol      = 1'b0;
    bus.cpha      = 1'b0;
    bus.lsb_first = 1'b0;
    bus.clk_div   = '0;
    bus.cs_sel    = '0;
    resp_word     = '0;
    loop_mode     = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_cs_n", bus.cs_n, 4'hF);
    check_output("reset_rx_data", bus.rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, MSB first, fastest clock, fixed slave reply
    apply_stimulus(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    wait_done(lat);
    check_output("t1_latency", lat, 18);
    check_output("t1_rx", bus.rx_data, 8'h3C);
    check_output("t1_mosi_word", last_mosi_word, 8'hA5);
    @(posedge clk); #2;
    check_output("t1_valid_one_cycle", bus.rx_valid, 1'b0);

    // All four modes with loopback
    for (int mode = 0; mode < 4; mode++) begin
      repeat (2) @(negedge clk);
      apply_stimulus(8'h5A, 8'h00, 1'b1, mode[1], mode[0], 1'b0, 8'd3, 2'd1);
      wait_done(lat);
      check_output("t2_latency", lat, 72);
      check_output("t2_rx", bus.rx_data, 8'h5A);
      check_output("t2_pulses", last_pulses, 8);
      @(posedge clk); #2;
      check_output("t2_idle_sclk", bus.sclk, mode[1]);
    end

    // LSB first
    repeat (2) @(negedge clk);
    apply_stimulus(8'h01, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd0);
    wait_done(lat);
    check_output("t3_latency", lat, 36);
    check_output("t3_rx", bus.rx_data, 8'hC3);
    check_output("t3_mosi_word", last_mosi_word, 8'h01);

    // Chip select decode, in range here and out of range on the 3-select instance
    repeat (2) @(negedge clk);
    apply_stimulus(8'h33, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 2'd2);
    @(posedge clk); #2;
    check_output("t4_cs_lead", bus.cs_n, 4'b1011);
    repeat (8) @(posedge clk);
    #2;
    check_output("t4_cs_xfer", bus.cs_n, 4'b1011);
    check_output("t4_cs3_none", bus3.cs_n, 3'b111);
    wait_done(lat);
    check_output("t4_rx3_valid", bus3.rx_valid, 1'b1);
    check_output("t4_rx3", bus3.rx_data, 8'h99);

    // Start while busy is ignored; start in the rx_valid cycle is taken
    repeat (2) @(negedge clk);
    apply_stimulus(8'h96, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 2'd0);
    repeat (5) @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = 8'hFF;
    bus.cpol    = 1'b1;
    bus.clk_div = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check_output("t5_latency", lat, 54);
    check_output("t5_rx", bus.rx_data, 8'h69);
    check_output("t5_cs_gap", bus.cs_n, 4'hF);
    apply_stimulus(8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    check_output("t5_cs_reasserted", bus.cs_n, 4'b1110);
    wait_done(lat);
    check_output("t5_b2b_rx", bus.rx_data, 8'h3C);

    // Reset in the middle of a shift
    repeat (2) @(negedge clk);
    apply_stimulus(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("t6_cs_n", bus.cs_n, 4'hF);
    check_output("t6_sclk", bus.sclk, 1'b0);
    check_output("t6_busy", bus.busy, 1'b0);
    check_output("t6_rx_valid", bus.rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    wait_done(lat);
    check_output("t6_latency", lat, 18);
    check_output("t6_rx", bus.rx_data, 8'h3C);

    // Randomised transfers, the last one at the largest divider
    for (int n = 0; n < 24; n++) begin
      tx = W'($urandom);
      rp = W'($urandom);
      lp = 1'($urandom_range(0, 1));
      dv = (n == 23) ? 8'd255 : DW'($urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply_stimulus(tx, rp, lp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), dv, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = W'($urandom);
        bus.cpol    = ~bus.cpol;
        bus.clk_div = DW'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done(lat);
      check_output("rand_latency", lat, (2 * W + 2) * (int'(dv) + 1));
      check_output("rand_rx", bus.rx_data, lp ? tx : rp);
    end
    check_output("max_div_latency", lat, 4608);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
